// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with 16x oversampling and a one-entry
// valid/ready holding register. Runs entirely in the clk_in domain: the
// oversample tick is a clock enable built from clk_cnt.
module uart_rx #(
  parameter int CLKS_PER_SAMPLE = 14,
  parameter int OVERSAMPLE      = 16
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [7:0]    CLK_LAST    = 8'(CLKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;
  logic [7:0]    clk_cnt;
  logic [SW-1:0] sample_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          tick;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Oversample tick: last clk_in cycle of each sample period.
  always_comb begin
    tick = (clk_cnt == CLK_LAST);
  end

  // Frame FSM with tick counters, shift register and holding register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      sample_cnt <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer drain; a completion below in the same cycle overrides it.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (state != IDLE) begin
        if (tick) begin
          clk_cnt    <= '0;
          sample_cnt <= sample_cnt + 1'b1;
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (rx_s_d && !rx_s) begin
            state      <= START;
            busy       <= 1'b1;
            clk_cnt    <= '0;
            sample_cnt <= '0;
          end
        end

        START: begin
          if (tick && sample_cnt == SAMPLE_MID) begin
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state      <= DATA;
              bit_idx    <= '0;
              clk_cnt    <= '0;
              sample_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (tick && sample_cnt == SAMPLE_LAST) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (tick && sample_cnt == SAMPLE_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (rx_s) begin
              if (!data_valid || data_ready) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (224 clk_in cycles/bit).
module tb_uart_rx;

  localparam int BIT_CLKS = 224;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int passes = 0;
  int checks = 0;
  int fails  = 0;

  int cyc = 0;
  int n_rise = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int last_rise = -1;
  logic dv_prev = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_SAMPLE(14), .OVERSAMPLE(16)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  always @(negedge clk_in) begin
    if (data_valid && !dv_prev) begin
      n_rise++;
      last_rise = cyc;
      got_q.push_back(data_out);
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    dv_prev = data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  int edge_cyc;
  int base_rise;
  int base_ferr;
  int base_ovr;
  int waited;
  logic [7:0] a5;

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    data_ready = 1'b0;
    wait_clks(3);

    // Reset values
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_clks(20);

    // 1. Single byte 0xA5, latency and busy through the frame
    a5 = 8'hA5;
    base_rise = n_rise;
    edge_cyc = cyc;
    drive_bit(1'b0);
    check("t1_busy_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive_bit(a5[i]);
      check("t1_busy_data", busy, 1'b1);
    end
    drive_bit(1'b1);
    check("t1_rises", n_rise - base_rise, 1);
    check_range("t1_latency", last_rise - edge_cyc, 2128, 2132);
    check("t1_data_out", data_out, 8'hA5);
    check("t1_data_valid", data_valid, 1'b1);
    check("t1_frame_err", n_ferr, 0);
    check("t1_busy_after", busy, 1'b0);
    data_ready = 1'b1;
    wait_clks(1);
    data_ready = 1'b0;
    check("t1_drained", data_valid, 1'b0);
    check("t1_data_kept", data_out, 8'hA5);
    wait_clks(20);

    // 2. Back-to-back bytes with data_ready tied high
    data_ready = 1'b1;
    got_q.delete();
    base_ovr = n_ovr;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_clks(5);
    check("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t2_byte0", got_q[0], 8'h00);
      check("t2_byte1", got_q[1], 8'hFF);
      check("t2_byte2", got_q[2], 8'h3C);
    end
    check("t2_no_overrun", n_ovr - base_ovr, 0);
    check("t2_valid_cleared", data_valid, 1'b0);
    data_ready = 1'b0;
    wait_clks(20);

    // 3. Overrun: second byte arrives while the first is unconsumed
    base_ovr = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check("t3_overrun_pulses", n_ovr - base_ovr, 1);
    check("t3_data_out", data_out, 8'h11);
    check("t3_data_valid", data_valid, 1'b1);
    data_ready = 1'b1;
    wait_clks(1);
    data_ready = 1'b0;
    check("t3_drained", data_valid, 1'b0);
    check("t3_data_kept", data_out, 8'h11);
    wait_clks(20);

    // 4. Framing error, then a clean frame
    base_ferr = n_ferr;
    base_rise = n_rise;
    send_frame(8'h5A, 1'b0);
    rx = 1'b1;
    wait_clks(50);
    check("t4_frame_err", n_ferr - base_ferr, 1);
    check("t4_no_valid", data_valid, 1'b0);
    check("t4_no_rise", n_rise - base_rise, 0);
    check("t4_busy_idle", busy, 1'b0);
    send_frame(8'h5A, 1'b1);
    check("t4_good_data", data_out, 8'h5A);
    check("t4_good_valid", data_valid, 1'b1);
    check("t4_no_new_ferr", n_ferr - base_ferr, 1);
    data_ready = 1'b1;
    wait_clks(1);
    data_ready = 1'b0;
    wait_clks(20);

    // 5. False start: 50-cycle low glitch
    base_ferr = n_ferr;
    base_rise = n_rise;
    base_ovr = n_ovr;
    edge_cyc = cyc;
    rx = 1'b0;
    wait_clks(20);
    check("t5_busy_high", busy, 1'b1);
    wait_clks(30);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 300) begin
      wait_clks(1);
      waited++;
    end
    check("t5_busy_fell", busy, 1'b0);
    check_range("t5_busy_time", cyc - edge_cyc, 110, 118);
    wait_clks(300);
    check("t5_no_valid", n_rise - base_rise, 0);
    check("t5_no_ferr", n_ferr - base_ferr, 0);
    check("t5_no_ovr", n_ovr - base_ovr, 0);

    // 6. Reset during bit 3 of 0xC3, then a clean 0x7E
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b0;
    wait_clks(112);
    check("t6_busy_mid", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data_out", data_out, 8'h00);
    check("t6_rst_valid", data_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_ferr", frame_err, 1'b0);
    check("t6_rst_ovr", overrun, 1'b0);
    rx = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(20);
    base_rise = n_rise;
    got_q.delete();
    send_frame(8'h7E, 1'b1);
    check("t6_rises", n_rise - base_rise, 1);
    check("t6_data_out", data_out, 8'h7E);
    check("t6_valid", data_valid, 1'b1);
    if (got_q.size() > 0) check("t6_first_byte", got_q[0], 8'h7E);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: 8N1 format, LSB first, 16x oversampling.
- Complements the team's baud-rate clock divider. The divider's fixed 14-cycle timing is rebuilt here as an internal clock-enable, not a derived clock, so the block runs entirely in the clk_in domain.
- Delivers received bytes to the consumer through a one-entry valid/ready holding register. Reports framing errors and overruns.

Parameters:
- CLKS_PER_SAMPLE, 14, clk_in cycles per oversample tick (range 2..255).
- OVERSAMPLE, 16, ticks per bit (fixed power of 2, ≥8). Bit period = CLKS_PER_SAMPLE*OVERSAMPLE = 224 clk_in cycles at the defaults.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous, idle high.
- data_out  output  8  last accepted byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- data_ready  input  1  consumer accepts data_out this cycle when data_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not being drained.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Interface (already decided): one clock, clk_in; reset rst_n is asynchronous, active-low.
- Reset: all state clears immediately on assertion, including mid-frame; any partial byte is discarded.
  - Output reset values: data_out=0x00, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops reset to 1. FSM resets to IDLE.
- Synchronizer: rx passes through 2 flops (rx_s). A registered rx_s_d provides edge detection.
- Tick generator: clk_cnt counts 0..CLKS_PER_SAMPLE-1; tick=1 when clk_cnt==CLKS_PER_SAMPLE-1. clk_cnt and sample_cnt (0..OVERSAMPLE-1) clear on entry to START and on entry to DATA.
- FSM states and transitions:
  - IDLE: rx_s_d=1 and rx_s=0 (falling edge) -> START.
  - START: on tick with sample_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - rx_s=1: false start -> IDLE, no flags.
    - rx_s=0: -> DATA, bit_idx=0.
  - DATA: on tick with sample_cnt==OVERSAMPLE-1, shift rx_s into shreg[7] (right shift, LSB first) and increment bit_idx. After the 8th bit -> STOP.
  - STOP: on tick with sample_cnt==OVERSAMPLE-1, sample rx_s, then -> IDLE.
    - Returning to IDLE at mid stop bit permits back-to-back frames.
    - rx_s=1: complete; shreg is offered to the holding register.
    - rx_s=0: frame_err pulses the next cycle; byte discarded; holding register untouched.
- Holding register and handshake (evaluated on the cycle of completion):
  - data_valid=0: load data_out, set data_valid.
  - data_valid=1 and data_ready=1 in the same cycle: load the new byte; data_valid stays 1.
  - data_valid=1 and data_ready=0: overrun pulses; new byte dropped; data_out unchanged.
  - No completion, data_valid=1 and data_ready=1: data_valid clears; data_out keeps its value.
  - data_ready with data_valid=0 is ignored.
- Latency: data_valid asserts 9.5 bit periods after the rx falling edge as seen at rx_s. At the defaults this is 2128 cycles, +3 cycles for synchronizer and output registering. Bench tolerance: 2128..2132 cycles from the pin edge.
- Noise:
  - Glitches shorter than half a bit are rejected by the start check.
  - No majority voting; single sample per bit.
  - A line held low (break) produces frame_err and then re-arms only on a new falling edge, since IDLE requires rx_s_d=1.

Test Plan:
1. Single byte: send 0xA5 at 224 cycles/bit with data_ready=0 -> data_valid rises within 2128..2132 cycles of the start edge; data_out=0xA5; frame_err=0; busy high throughout the frame. Then pulse data_ready -> data_valid=0 the next cycle.
2. Back-to-back bytes: send 0x00, 0xFF, 0x3C with no idle gap and data_ready tied 1 -> three completions with data_out 0x00, 0xFF, 0x3C in order; no overrun.
3. Overrun: send 0x11, then 0x22, with data_ready=0 -> data_out=0x11; one overrun pulse at the second completion. Then data_ready=1 -> reads 0x11 and data_valid clears.
4. Framing error: send 0x5A with stop bit low -> one frame_err pulse; data_valid remains 0. Return line high, send 0x5A correctly -> data_out=0x5A.
5. False start: drive a 50-cycle low glitch on rx -> busy returns to 0 after about 112 cycles; no data_valid, no flags.
6. Reset mid-frame: assert rst_n=0 during bit 3 of 0xC3 -> all outputs at reset values. Release, send 0x7E -> data_out=0x7E; no corrupted byte.
